// File: rtl/bp_io_uc_responder.sv
// IO-side uncached responder: accepts one bedrock uc_rd/uc_wr command at a time, services it
// against a local 64-bit scratchpad, and returns a response after a fixed latency.
// Message layout (LSB first): msg_type[3:0], addr[paddr], size[2:0], payload, then data.
module bp_io_uc_responder #(
  parameter int unsigned paddr_width_p     = 40,
  parameter int unsigned cce_block_width_p = 512,
  parameter int unsigned payload_width_p   = 16,
  parameter int unsigned els_p             = 16,
  parameter int unsigned latency_p         = 2,
  localparam int unsigned hdr_width_lp         = 4 + paddr_width_p + 3 + payload_width_p,
  localparam int unsigned cce_mem_msg_width_lp = hdr_width_lp + cce_block_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
  input  logic                            io_cmd_v_i,
  output logic                            io_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
  output logic                            io_resp_v_o,
  input  logic                            io_resp_yumi_i
);

  localparam int unsigned idx_width_lp = $clog2(els_p);
  localparam int unsigned cnt_width_lp = (latency_p > 0) ? $clog2(latency_p + 1) : 1;

  localparam logic [3:0] e_mem_msg_uc_rd = 4'd2;
  localparam logic [3:0] e_mem_msg_uc_wr = 4'd3;

  typedef enum logic [1:0] {e_ready, e_wait, e_resp} state_e;

  state_e                    state_q, state_d;
  logic [cnt_width_lp-1:0]   cnt_q, cnt_d;
  logic [hdr_width_lp-1:0]   resp_hdr_q;
  logic [cce_block_width_p-1:0] resp_data_q, resp_data_d;
  logic [63:0]               mem_q [els_p];

  logic [hdr_width_lp-1:0]      cmd_hdr;
  logic [cce_block_width_p-1:0] cmd_data;
  logic [3:0]                   msg_type;
  logic [paddr_width_p-1:0]     addr;
  logic [2:0]                   size;
  logic [idx_width_lp-1:0]      idx;
  logic [7:0]                   byte_mask;
  logic [2:0]                   off_mask, off;
  logic [5:0]                   shamt;
  logic [63:0]                  lane_mask, old_word, wr_word, rd_word;
  logic                         accept, is_rd, is_wr;

  assign cmd_hdr  = io_cmd_i[hdr_width_lp-1:0];
  assign cmd_data = io_cmd_i[hdr_width_lp+:cce_block_width_p];
  assign msg_type = cmd_hdr[3:0];
  assign addr     = cmd_hdr[4+:paddr_width_p];
  assign size     = cmd_hdr[4+paddr_width_p+:3];
  // Upper address bits alias onto the scratchpad
  assign idx      = addr[3+:idx_width_lp];
  assign is_rd    = (msg_type == e_mem_msg_uc_rd);
  assign is_wr    = (msg_type == e_mem_msg_uc_wr);

  logic unused_bits;
  assign unused_bits = ^{cmd_data[cce_block_width_p-1:64], addr[paddr_width_p-1:3+idx_width_lp]};

  assign io_cmd_ready_o = (state_q == e_ready) && !reset_i;
  assign accept         = io_cmd_v_i && io_cmd_ready_o;
  assign io_resp_v_o    = (state_q == e_resp);
  assign io_resp_o      = {resp_data_q, resp_hdr_q};

  // Size decode, offset alignment and byte-lane merge/extract for the addressed word
  always_comb begin
    byte_mask = 8'hFF;
    off_mask  = 3'b000;
    unique case (size)
      3'd0:    begin byte_mask = 8'h01; off_mask = 3'b111; end
      3'd1:    begin byte_mask = 8'h03; off_mask = 3'b110; end
      3'd2:    begin byte_mask = 8'h0F; off_mask = 3'b100; end
      default: begin byte_mask = 8'hFF; off_mask = 3'b000; end
    endcase
    off   = addr[2:0] & off_mask;
    shamt = {off, 3'b000};
    lane_mask = '0;
    for (int b = 0; b < 8; b++) lane_mask[8*b+:8] = {8{byte_mask[b]}};
    old_word = mem_q[idx];
    wr_word  = (old_word & ~(lane_mask << shamt)) | ((cmd_data[63:0] & lane_mask) << shamt);
    rd_word  = (old_word >> shamt) & lane_mask;
    resp_data_d = is_rd ? cce_block_width_p'(rd_word) : '0;
  end

  // FSM state and latency counter registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_ready;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: ready -> (wait while counter runs) -> resp until consumed
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      e_ready: begin
        if (accept) begin
          cnt_d   = cnt_width_lp'(latency_p);
          state_d = (latency_p > 0) ? e_wait : e_resp;
        end
      end
      e_wait: begin
        cnt_d = cnt_q - cnt_width_lp'(1);
        if (cnt_q == cnt_width_lp'(1)) state_d = e_resp;
      end
      e_resp: begin
        if (io_resp_yumi_i) state_d = e_ready;
      end
      default: state_d = e_ready;
    endcase
  end

  // Scratchpad and response capture; read data is taken at accept time
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      resp_hdr_q  <= '0;
      resp_data_q <= '0;
      for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
    end else if (accept) begin
      resp_hdr_q  <= cmd_hdr;
      resp_data_q <= resp_data_d;
      if (is_wr) mem_q[idx] <= wr_word;
    end
  end

endmodule
